pong_hv_counter: RTL and testbench

//  Horizontal/vertical timing counter chain. Synchronous equivalent of the 9316/7493 H and V counter chains.

---
 rtl/pong_hv_counter_if.sv | 22 ++
 rtl/pong_hv_counter.sv | 73 +++++++
 tb/tb_pong_hv_counter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pong_hv_counter_if.sv
// Raster timing bundle: pixel-clock enable in, H/V counts and decoded strobes out.
interface pong_hv_counter_if;
    logic       ce;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       hreset;
    logic       vreset;
    logic       hblank;
    logic       vblank;
    logic       hsync;
    logic       vsync;

    modport master (
        input  ce,
        output hcount, vcount, hreset, vreset, hblank, vblank, hsync, vsync
    );

    modport slave (
        output ce,
        input  hcount, vcount, hreset, vreset, hblank, vblank, hsync, vsync
    );
endinterface

// File: rtl/pong_hv_counter.sv
// Synchronous H/V raster counter chain with registered blank/sync/reset strobes.
module pong_hv_counter #(
    parameter int H_TOTAL      = 455,
    parameter int H_BLANK_END  = 80,
    parameter int H_SYNC_START = 32,
    parameter int H_SYNC_END   = 64,
    parameter int V_TOTAL      = 262,
    parameter int V_BLANK_END  = 16,
    parameter int V_SYNC_START = 4,
    parameter int V_SYNC_END   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pong_hv_counter_if.master  tim
);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    // Window bounds may equal 512, so compare in 10 bits.
    localparam logic [9:0] HB_END = 10'(H_BLANK_END);
    localparam logic [9:0] HS_BEG = 10'(H_SYNC_START);
    localparam logic [9:0] HS_END = 10'(H_SYNC_END);
    localparam logic [9:0] VB_END = 10'(V_BLANK_END);
    localparam logic [9:0] VS_BEG = 10'(V_SYNC_START);
    localparam logic [9:0] VS_END = 10'(V_SYNC_END);

    logic [8:0] hcnt, vcnt;
    logic [8:0] h_nxt, v_nxt;
    logic [9:0] h_nxt_w, v_nxt_w;
    logic       h_wrap;
    logic       hreset_q, vreset_q, hblank_q, vblank_q, hsync_q, vsync_q;

    always_comb begin
        h_wrap = (hcnt == H_LAST);
        h_nxt  = h_wrap ? 9'd0 : hcnt + 9'd1;
        v_nxt  = vcnt;
        if (h_wrap)
            v_nxt = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
        h_nxt_w = {1'b0, h_nxt};
        v_nxt_w = {1'b0, v_nxt};
    end

    // Strobes decode the next-state count so they line up with the count they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            hreset_q <= 1'b0;
            vreset_q <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
        end else if (tim.ce) begin
            hcnt     <= h_nxt;
            vcnt     <= v_nxt;
            hreset_q <= (h_nxt == H_LAST);
            vreset_q <= (v_nxt == V_LAST);
            hblank_q <= (h_nxt_w < HB_END);
            vblank_q <= (v_nxt_w < VB_END);
            hsync_q  <= (h_nxt_w >= HS_BEG) && (h_nxt_w < HS_END);
            vsync_q  <= (v_nxt_w >= VS_BEG) && (v_nxt_w < VS_END);
        end
    end

    assign tim.hcount = hcnt;
    assign tim.vcount = vcnt;
    assign tim.hreset = hreset_q;
    assign tim.vreset = vreset_q;
    assign tim.hblank = hblank_q;
    assign tim.vblank = vblank_q;
    assign tim.hsync  = hsync_q;
    assign tim.vsync  = vsync_q;
endmodule

// File: tb/tb_pong_hv_counter.sv
// Bench: default-timing instance plus a shrunken instance for full-frame coverage, both checked against a ce-edge-count model.
module tb_pong_hv_counter;
    localparam int BHT = 23, BHBE = 7, BHSS = 2, BHSE = 5;
    localparam int BVT = 11, BVBE = 3, BVSS = 1, BVSE = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic ce_a = 1'b0, ce_b = 1'b0;
    int   mode_a = 0, mode_b = 0;
    int   ph_a = 0, ph_b = 0;
    longint na, nb;
    bit   chk_on = 1'b0;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    pong_hv_counter_if bus_a ();
    pong_hv_counter_if bus_b ();
    assign bus_a.ce = ce_a;
    assign bus_b.ce = ce_b;

    pong_hv_counter dut_a (.clk(clk), .rst_n(rst_n), .tim(bus_a));

    pong_hv_counter #(
        .H_TOTAL(BHT), .H_BLANK_END(BHBE), .H_SYNC_START(BHSS), .H_SYNC_END(BHSE),
        .V_TOTAL(BVT), .V_BLANK_END(BVBE), .V_SYNC_START(BVSS), .V_SYNC_END(BVSE)
    ) dut_b (.clk(clk), .rst_n(rst_n), .tim(bus_b));

    // Whole state follows from the number of ce edges since reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            na <= 0;
            nb <= 0;
        end else begin
            if (ce_a) na <= na + 1;
            if (ce_b) nb <= nb + 1;
        end
    end

    function automatic logic [23:0] model(longint n, int ht, int hbe, int hss, int hse,
                                          int vt, int vbe, int vss, int vse);
        int h, v;
        h = int'(n % longint'(ht));
        v = int'((n / longint'(ht)) % longint'(vt));
        return {9'(h), 9'(v), (h == ht - 1), (v == vt - 1), (h < hbe), (v < vbe),
                (h >= hss && h < hse), (v >= vss && v < vse)};
    endfunction

    function automatic logic [23:0] pack_a();
        return {bus_a.hcount, bus_a.vcount, bus_a.hreset, bus_a.vreset,
                bus_a.hblank, bus_a.vblank, bus_a.hsync, bus_a.vsync};
    endfunction

    function automatic logic [23:0] pack_b();
        return {bus_b.hcount, bus_b.vcount, bus_b.hreset, bus_b.vreset,
                bus_b.hblank, bus_b.vblank, bus_b.hsync, bus_b.vsync};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h (h,v,hrst,vrst,hbl,vbl,hs,vs)", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chkv("model_a", pack_a(), model(na, 455, 80, 32, 64, 262, 16, 4, 8));
            chkv("model_b", pack_b(), model(nb, BHT, BHBE, BHSS, BHSE, BVT, BVBE, BVSS, BVSE));
            chk("range_a", int'(bus_a.hcount < 9'd455 && bus_a.vcount < 9'd262), 1);
            chk("range_b", int'(bus_b.hcount < 9'(BHT) && bus_b.vcount < 9'(BVT)), 1);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            case (mode_a)
                1: ce_a = 1'b1;
                2: begin ce_a = (ph_a == 2); ph_a = (ph_a + 1) % 3; end
                3: ce_a = 1'($urandom_range(0, 1));
                default: ce_a = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            case (mode_b)
                1: ce_b = 1'b1;
                2: begin ce_b = (ph_b == 2); ph_b = (ph_b + 1) % 3; end
                3: ce_b = 1'($urandom_range(0, 1));
                default: ce_b = 1'b0;
            endcase
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hr_cnt, vr_rise, pulses;
        bit prev_vr, done;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        tick(3);
        chk("rst_hcount", int'(bus_a.hcount), 0);
        chk("rst_hblank", int'(bus_a.hblank), 1);
        chk("rst_vblank", int'(bus_a.vblank), 1);
        chk("rst_hsync", int'(bus_a.hsync), 0);

        rst_n = 1'b1;
        mode_a = 1;
        mode_b = 3;
        tick(31);
        chk("h31_hsync", int'(bus_a.hsync), 0);
        chk("h31_hcount", int'(bus_a.hcount), 31);
        tick(1);
        chk("h32_hsync", int'(bus_a.hsync), 1);
        tick(31);
        chk("h63_hsync", int'(bus_a.hsync), 1);
        tick(1);
        chk("h64_hsync", int'(bus_a.hsync), 0);
        tick(15);
        chk("h79_hblank", int'(bus_a.hblank), 1);
        tick(1);
        chk("h80_hblank", int'(bus_a.hblank), 0);
        tick(374);
        chk("h454_hcount", int'(bus_a.hcount), 454);
        chk("h454_hreset", int'(bus_a.hreset), 1);
        tick(1);
        chk("wrap1_hcount", int'(bus_a.hcount), 0);
        chk("wrap1_vcount", int'(bus_a.vcount), 1);
        chk("wrap1_hreset", int'(bus_a.hreset), 0);
        tick(4549);
        chk("v10_hcount", int'(bus_a.hcount), 454);
        chk("v10_vcount", int'(bus_a.vcount), 10);
        tick(1);
        chk("v11_hcount", int'(bus_a.hcount), 0);
        chk("v11_vcount", int'(bus_a.vcount), 11);
        chk("v11_hblank", int'(bus_a.hblank), 1);
        chk("v11_hreset", int'(bus_a.hreset), 0);
        tick(200);
        chk("mid_hcount", int'(bus_a.hcount), 200);

        // Mid-line async reset: must take effect with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hcount", int'(bus_a.hcount), 0);
        chk("arst_vcount", int'(bus_a.vcount), 0);
        chk("arst_hblank", int'(bus_a.hblank), 1);
        chk("arst_vblank", int'(bus_a.vblank), 1);
        chk("arst_strobes", int'({bus_a.hreset, bus_a.vreset, bus_a.hsync, bus_a.vsync}), 0);
        mode_a = 3;
        mode_b = 1;
        tick(2);
        rst_n = 1'b1;

        hr_cnt = 0;
        vr_rise = 0;
        prev_vr = 1'b0;
        for (int i = 1; i <= 3 * BHT * BVT; i++) begin
            tick(1);
            if (bus_b.hreset) hr_cnt++;
            if (bus_b.vreset && !prev_vr) vr_rise++;
            prev_vr = bus_b.vreset;
            if (i == BHT * BVT - 1) begin
                chk("fend_hcount", int'(bus_b.hcount), BHT - 1);
                chk("fend_vcount", int'(bus_b.vcount), BVT - 1);
                chk("fend_vreset", int'(bus_b.vreset), 1);
            end
            if (i == BHT * BVT) begin
                chk("fwrap_hv", int'({bus_b.hcount, bus_b.vcount}), 0);
                chk("fwrap_vreset", int'(bus_b.vreset), 0);
                chk("fwrap_blank", int'({bus_b.hblank, bus_b.vblank}), 3);
            end
        end
        chk("hreset_pulses", hr_cnt, 3 * BVT);
        chk("vreset_lines", vr_rise, 3);

        mode_b = 2;
        pulses = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick(1);
            if (ce_b) begin
                pulses++;
                if (bus_b.hcount == 9'd0 && bus_b.vcount == 9'd0) done = 1'b1;
            end
        end
        chk("frame_done", int'(done), 1);
        chk("frame_period", pulses, BHT * BVT);

        mode_b = 3;
        tick(3000);
        mode_a = 2;
        tick(1500);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
